rstl_max_seq: RTL and testbench
===============================

Name: rstl_max_seq

Overview:
- Sequencer for the 3-filter max-pool result memory.
- Write phase: counts pooled outputs from three parallel pooling units and drives write enable plus three per-filter write addresses, one plane of 169 entries per filter.
- Read phase: streams all 507 entries out in order under a ready handshake and drives the read enable and read address.
- Sits between the pooling units and the result memory on one side, and the next layer (flatten/dense) on the other.

Parameters:
- N_POOL, 169, entries per filter plane (13x13 pooled map).
- NUM_ENTRIES, 507, total memory depth (3*N_POOL).
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= NUM_ENTRIES.

Ports:
- clk  in  1  single system clock; the memory read clock is tied to clk in this configuration.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a write phase; honoured only in IDLE.
- pool_valid  in  1  pooling units present data_in1..3 this cycle.
- wen  out  1  memory write enable.
- wadd1  out  ADDR_W  filter-0 write address.
- wadd2  out  ADDR_W  filter-1 write address.
- wadd3  out  ADDR_W  filter-2 write address.
- rd_ready  in  1  downstream can accept a word in the next cycle.
- ren  out  1  memory read enable.
- radd  out  ADDR_W  memory read address.
- rdata_valid  out  1  memory rdata is valid this cycle.
- rd_last  out  1  accompanies rdata_valid for the final word.
- busy  out  1  high in WRITE, READ or DONE.
- done  out  1  one-cycle completion pulse.
- err_overrun  out  1  sticky flag: pool_valid arrived outside WRITE.

Behaviour:
Reset:
- Synchronous on rst; state=IDLE, all counters=0.
- wen=ren=rdata_valid=rd_last=done=busy=err_overrun=0; wadd1..3=0, radd=0.
- Reset mid-operation aborts immediately; no further wen or ren is issued.

States:
- IDLE: start -> WRITE; err_overrun cleared in the same cycle.
- WRITE:
  - Counter widx in 0..N_POOL-1.
  - wen = pool_valid (combinational, same cycle, so it aligns with the pooling data).
  - wadd1=widx, wadd2=widx+N_POOL, wadd3=widx+2*N_POOL (registered counter plus constant adds; no wrap).
  - On pool_valid, widx increments. pool_valid with widx=N_POOL-1 writes the last triple and moves to READ next cycle with widx=0.
  - Gaps in pool_valid simply stall the counter.
- READ:
  - Counter ridx in 0..NUM_ENTRIES-1; radd = read-order address of ridx.
  - ren = rd_ready (combinational); ridx increments when ren=1.
  - Read latency is 1 cycle: rdata_valid is the registered ren; rd_last is the registered (ren and ridx=NUM_ENTRIES-1).
  - ren with ridx=NUM_ENTRIES-1 moves to DONE.
- DONE:
  - Single cycle; rdata_valid and rd_last are high for the final word, done=1.
  - -> IDLE.

Boundary and error rules:
- start outside IDLE is ignored.
- start and pool_valid in the same cycle in IDLE: start is taken, pool_valid is flagged as overrun and not written.
- pool_valid in IDLE, READ or DONE: wen stays 0 and err_overrun is set (sticky until the next accepted start or reset).
- rd_ready low stalls READ indefinitely with ren=0 and radd held.
- busy is the registered state != IDLE.

Default read order: plane order; radd=ridx, so 0..168 is filter 0, 169..337 is filter 1, 338..506 is filter 2.

Optional Feature:
- Macro RSTL_MAX_INTERLEAVE_EN.
- When defined:
  - Read order is interleaved per position: radd = pos + f*N_POOL.
  - f cycles 0,1,2 and is the inner counter; pos runs 0..168 and is the outer counter.
  - Sequence is 0,169,338,1,170,339,...,168,337,506.
- When undefined: plane order as above.
- Total read count, handshake, latency and rd_last position are identical in both modes.

Test Plan:
- Reset then start, 169 back-to-back pool_valid pulses -> 169 wen pulses; first triple (0,169,338), last triple (168,337,506); READ entered the cycle after the last write.
- pool_valid with 1-cycle gaps between pulses -> exactly 169 writes; widx holds during gaps; no skipped addresses.
- READ with rd_ready constantly 1 -> radd 0..506 on consecutive cycles; rdata_valid one cycle after each ren; rd_last and done together on the 507th rdata_valid; IDLE the following cycle.
- READ with rd_ready toggling 1,0,1,0 -> ren only when rd_ready=1; radd held while stalled; 507 valid words total.
- pool_valid in IDLE, then start -> err_overrun=1 with no wen; start clears err_overrun; start pulsed during READ is ignored.
- rst asserted at widx=50 -> next cycle state=IDLE and all outputs 0; a fresh start writes from address 0. With RSTL_MAX_INTERLEAVE_EN defined, the first reads are radd 0,169,338,1 and the last is 506.

Source files
------------

// File: rtl/rstl_max_seq.sv
// rstl_max_seq: sequencer for the 3-filter max-pool result memory.
//
// Write phase: counts pooled outputs from three parallel pooling units and
// drives a write enable plus one write address per filter plane.
// Read phase: streams every entry out under a ready handshake with a
// one-cycle read latency.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start                    begins a write phase (honoured only in IDLE)
//   pool_valid               pooling units present data this cycle
//   wen, wadd1..wadd3        memory write enable and per-filter addresses
//   rd_ready                 downstream can take a word next cycle
//   ren, radd                memory read enable and address
//   rdata_valid, rd_last     read data qualifier and final-word marker
//   busy, done, err_overrun  status outputs
//
// Build option: define RSTL_MAX_INTERLEAVE_EN to read in per-position
// interleaved order (0,169,338,1,...) instead of plane order.
module rstl_max_seq #(
  parameter int unsigned N_POOL      = 169,
  parameter int unsigned NUM_ENTRIES = 507,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pool_valid,
  output logic              wen,
  output logic [ADDR_W-1:0] wadd1,
  output logic [ADDR_W-1:0] wadd2,
  output logic [ADDR_W-1:0] wadd3,
  input  logic              rd_ready,
  output logic              ren,
  output logic [ADDR_W-1:0] radd,
  output logic              rdata_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] PLANE1 = ADDR_W'(N_POOL);
  localparam logic [ADDR_W-1:0] PLANE2 = ADDR_W'(2 * N_POOL);
  localparam logic [ADDR_W-1:0] WLAST  = ADDR_W'(N_POOL - 1);
  localparam logic [ADDR_W-1:0] RLAST  = ADDR_W'(NUM_ENTRIES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] ridx_q, ridx_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              err_q, err_d;
  logic              in_write, in_read, w_fire, r_fire;
  logic [ADDR_W-1:0] rd_addr;

  assign in_write = (state_q == WRITE);
  assign in_read  = (state_q == READ);
  // Gate with rst so a reset cycle never issues a write or read.
  assign w_fire   = in_write & pool_valid & ~rst;
  assign r_fire   = in_read & rd_ready & ~rst;

  assign wen         = w_fire;
  assign wadd1       = in_write ? widx_q : '0;
  assign wadd2       = in_write ? widx_q + PLANE1 : '0;
  assign wadd3       = in_write ? widx_q + PLANE2 : '0;
  assign ren         = r_fire;
  assign radd        = in_read ? rd_addr : '0;
  assign rdata_valid = rvalid_q;
  assign rd_last     = rlast_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err_overrun = err_q;

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    ridx_d   = ridx_q;
    rvalid_d = r_fire;
    rlast_d  = r_fire && (ridx_q == RLAST);
    err_d    = err_q | (pool_valid & ~in_write);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          widx_d  = '0;
          // Accepted start clears the flag, but a coincident pool_valid is still an overrun.
          err_d   = pool_valid;
        end
      end
      WRITE: begin
        if (w_fire) begin
          if (widx_q == WLAST) begin
            state_d = READ;
            widx_d  = '0;
            ridx_d  = '0;
          end else begin
            widx_d = widx_q + ADDR_W'(1);
          end
        end
      end
      READ: begin
        if (r_fire) begin
          if (ridx_q == RLAST) begin
            state_d = DONE;
            ridx_d  = '0;
          end else begin
            ridx_d = ridx_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      widx_q   <= '0;
      ridx_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      ridx_q   <= ridx_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      err_q    <= err_d;
    end
  end

`ifdef RSTL_MAX_INTERLEAVE_EN
  // Filter select is the inner counter, position the outer one.
  logic [ADDR_W-1:0] pos_q, pos_d, plane_base;
  logic [1:0]        fsel_q, fsel_d;

  always_comb begin
    pos_d  = pos_q;
    fsel_d = fsel_q;
    if (!in_read) begin
      pos_d  = '0;
      fsel_d = '0;
    end else if (r_fire) begin
      if (fsel_q == 2'd2) begin
        fsel_d = 2'd0;
        pos_d  = pos_q + ADDR_W'(1);
      end else begin
        fsel_d = fsel_q + 2'd1;
      end
    end
  end

  always_comb begin
    case (fsel_q)
      2'd0:    plane_base = '0;
      2'd1:    plane_base = PLANE1;
      default: plane_base = PLANE2;
    endcase
  end

  assign rd_addr = pos_q + plane_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      fsel_q <= 2'd0;
    end else begin
      pos_q  <= pos_d;
      fsel_q <= fsel_d;
    end
  end
`else
  assign rd_addr = ridx_q;
`endif

endmodule

// File: tb/tb_rstl_max_seq.sv
module tb_rstl_max_seq;
  localparam int unsigned NPool = 169;
  localparam int unsigned NEnt  = 507;
  localparam int unsigned AW    = 10;

  logic clk = 1'b0;
  logic rst, start, pool_valid, rd_ready;
  logic wen, ren, rdata_valid, rd_last, busy, done, err_overrun;
  logic [AW-1:0] wadd1, wadd2, wadd3, radd;

  always #5 clk = ~clk;

  rstl_max_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pool_valid  (pool_valid),
    .wen         (wen),
    .wadd1       (wadd1),
    .wadd2       (wadd2),
    .wadd3       (wadd3),
    .rd_ready    (rd_ready),
    .ren         (ren),
    .radd        (radd),
    .rdata_valid (rdata_valid),
    .rd_last     (rd_last),
    .busy        (busy),
    .done        (done),
    .err_overrun (err_overrun)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 writing, 2 reading, 3 done.
  int m_phase = 0;
  int m_w     = 0;
  int m_r     = 0;
  bit m_err   = 0;
  bit m_vp    = 0;
  bit m_lp    = 0;
  int wen_seen = 0, rv_seen = 0, last_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // k-th address of the read stream.
  function automatic int order(input int k);
`ifdef RSTL_MAX_INTERLEAVE_EN
    return (k % 3) * NPool + k / 3;
`else
    return k;
`endif
  endfunction

  // Compare all outputs against the model at negedge, then advance model.
  task automatic step();
    logic [63:0] exp_v, got_v;
    bit e_wen, e_ren;
    int wa1, wa2, wa3, ra;
    @(negedge clk);
    e_wen = (m_phase == 1) && pool_valid && !rst;
    e_ren = (m_phase == 2) && rd_ready && !rst;
    wa1 = (m_phase == 1) ? m_w : 0;
    wa2 = (m_phase == 1) ? m_w + NPool : 0;
    wa3 = (m_phase == 1) ? m_w + 2 * NPool : 0;
    ra  = (m_phase == 2) ? order(m_r) : 0;
    exp_v = {17'd0, e_wen, 10'(wa1), 10'(wa2), 10'(wa3), e_ren, 10'(ra),
             m_vp, m_lp, (m_phase != 0), (m_phase == 3), m_err};
    got_v = {17'd0, wen, wadd1, wadd2, wadd3, ren, radd,
             rdata_valid, rd_last, busy, done, err_overrun};
    check("cycle", got_v, exp_v);
    if (wen === 1'b1) wen_seen++;
    if (rdata_valid === 1'b1) rv_seen++;
    if (rd_last === 1'b1) last_seen++;
    if (rst) begin
      m_phase = 0; m_w = 0; m_r = 0; m_err = 0; m_vp = 0; m_lp = 0;
    end else begin
      m_vp = e_ren;
      m_lp = e_ren && (m_r == NEnt - 1);
      if (pool_valid && m_phase != 1) m_err = 1;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_w = 0; m_err = pool_valid; end
        1: if (pool_valid) begin
             if (m_w == NPool - 1) begin m_phase = 2; m_w = 0; m_r = 0; end
             else m_w++;
           end
        2: if (e_ren) begin
             if (m_r == NEnt - 1) begin m_phase = 3; m_r = 0; end
             else m_r++;
           end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs from just after an accepted start until the model is idle again.
  task automatic run(input int pv_mode, input int rr_mode, input bit poke_start,
                     input int budget);
    int n = 0;
    int w0 = wen_seen, v0 = rv_seen, l0 = last_seen;
    while (m_phase != 0 && n < budget) begin
      if (m_phase == 1) pool_valid = pick(pv_mode, n);
      else pool_valid = (pv_mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
      rd_ready = pick(rr_mode, n);
      start = poke_start && (m_phase == 2) && (n % 37 == 0);
      step();
      n++;
    end
    start = 0; pool_valid = 0;
    check("budget", 64'(n < budget), 64'd1);
    check("wen_count", 64'(wen_seen - w0), 64'(NPool));
    check("rvalid_count", 64'(rv_seen - v0), 64'(NEnt));
    check("last_count", 64'(last_seen - l0), 64'd1);
    step();
  endtask

  initial begin
    rst = 1; start = 0; pool_valid = 0; rd_ready = 0;
    repeat (3) step();
    rst = 0;
    step();
    // Overrun in IDLE, then start clears it.
    pool_valid = 1; step();
    pool_valid = 0; step();
    check("err_sticky", 64'(err_overrun), 64'd1);
    start = 1; step(); start = 0;
    check("err_cleared", 64'(err_overrun), 64'd0);
    run(0, 0, 1, 4000);
    // Coincident start and pool_valid, then gapped writes and toggling ready.
    start = 1; pool_valid = 1; step(); start = 0; pool_valid = 0;
    check("err_coincident", 64'(err_overrun), 64'd1);
    run(1, 1, 0, 4000);
    repeat (2) begin
      start = 1; step(); start = 0;
      run(2, 2, 1, 8000);
    end
    // Reset in the middle of the write phase.
    start = 1; step(); start = 0;
    pool_valid = 1;
    for (int i = 0; i < 60 && m_w < 50; i++) step();
    check("widx_at_50", 64'(wadd1), 64'd50);
    rst = 1; step();
    rst = 0; pool_valid = 0; step();
    check("idle_after_rst", 64'(busy), 64'd0);
    start = 1; step(); start = 0;
    run(0, 0, 0, 4000);
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
